// File: rtl/clct_subkey_deadtime_pkg.sv
// pattern_params: constants and types shared by the subkey dead-time filter.
//   MXSUBKEYBX/MXHITB/MXPIDB/MXAGEB : default field widths
//   SUBKEY_MAX   : largest legal quarter-strip subkey
//   SUBKEY_SPLIT : first ME1/1a subkey (region boundary)
//   hist_entry_t : one history slot {vld, subkey, nhits, age}
//   abs_diff11   : 11-bit unsigned |a-b| of two subkeys
package pattern_params;
  localparam int MXSUBKEYBX   = 10;
  localparam int MXHITB       = 3;
  localparam int MXPIDB       = 4;
  localparam int MXAGEB       = 4;
  localparam int SUBKEY_MAX   = 895;
  localparam int SUBKEY_SPLIT = 512;

  typedef struct packed {
    logic                  vld;
    logic [MXSUBKEYBX-1:0] subkey;
    logic [MXHITB-1:0]     nhits;
    logic [MXAGEB-1:0]     age;
  } hist_entry_t;

  function automatic logic [10:0] abs_diff11(input logic [MXSUBKEYBX-1:0] a,
                                             input logic [MXSUBKEYBX-1:0] b);
    return (a >= b) ? (11'(a) - 11'(b)) : (11'(b) - 11'(a));
  endfunction
endpackage

// File: rtl/clct_subkey_deadtime_hist.sv
// subkey_hist_entry: one history slot of the dead-time filter.
// Holds an accepted candidate, ages it every bx (saturating) and flags a match
// against the S1 candidate.
//   clock, reset_n      : bx clock, synchronous active-low reset
//   i_wr, i_wr_*        : load a freshly accepted candidate (age restarts at 0)
//   i_cand_*            : S1 candidate under comparison
//   i_dead_bx           : dead time; entries at age >= i_dead_bx never match
//   i_window_qs         : half-window in quarter-strips
//   o_match             : this slot suppresses the S1 candidate
// Macro SUBKEY_REGION_SPLIT_EN: when defined, ME1/1b (<512) and ME1/1a (>=512)
// subkeys never match each other.
// Widths must equal the pattern_params defaults (slot state uses hist_entry_t).
module subkey_hist_entry #(
  parameter int MXSUBKEYBX = 10,
  parameter int MXHITB     = 3,
  parameter int MXAGEB     = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_wr,
  input  logic [MXSUBKEYBX-1:0] i_wr_subkey,
  input  logic [MXHITB-1:0]     i_wr_nhits,
  input  logic [MXSUBKEYBX-1:0] i_cand_subkey,
  input  logic [MXHITB-1:0]     i_cand_nhits,
  input  logic [MXAGEB-1:0]     i_dead_bx,
  input  logic [4:0]            i_window_qs,
  output logic                  o_match
);
  import pattern_params::*;

  localparam logic [MXAGEB-1:0] AGE_SAT = '1;

  hist_entry_t r_ent;
  logic [10:0] w_diff;
  logic        w_region_ok;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ent <= '0;
    end else if (i_wr) begin
      r_ent.vld    <= 1'b1;
      r_ent.subkey <= i_wr_subkey;
      r_ent.nhits  <= i_wr_nhits;
      r_ent.age    <= '0;
    end else if (r_ent.vld && (r_ent.age != AGE_SAT)) begin
      r_ent.age <= r_ent.age + 1'b1;
    end
  end

  assign w_diff = abs_diff11(i_cand_subkey, r_ent.subkey);

`ifdef SUBKEY_REGION_SPLIT_EN
  localparam logic [MXSUBKEYBX-1:0] SPLIT_K = MXSUBKEYBX'(SUBKEY_SPLIT);
  assign w_region_ok = ((i_cand_subkey >= SPLIT_K) == (r_ent.subkey >= SPLIT_K));
`else
  assign w_region_ok = 1'b1;
`endif

  // The window does not wrap: a plain magnitude compare.
  assign o_match = r_ent.vld
                 & (r_ent.age < i_dead_bx)
                 & (w_diff <= {6'b0, i_window_qs})
                 & (r_ent.nhits >= i_cand_nhits)
                 & w_region_ok;
endmodule

// File: rtl/clct_subkey_deadtime.sv
// clct_subkey_deadtime: quarter-strip dead-time / ghost filter after the
// best-key subkey calculation. Candidates close (within window_qs) to a
// recently accepted candidate with >= hits are killed. Fixed 2-clock latency.
//   clock, reset_n                    : bx clock, synchronous active-low reset
//   dead_bx, window_qs                : dead time (0 = off), half-window
//   cand_vld/subkey/nhits/pid         : one candidate per bx
//   out_vld/subkey/nhits/pid          : accepted candidate (data holds when idle)
//   kill                              : candidate suppressed (pulse)
//   range_err                         : candidate subkey > 895 (pulse)
// Macro SUBKEY_REGION_SPLIT_EN: blocks matches across the 511/512 boundary.
module clct_subkey_deadtime #(
  parameter int MXSUBKEYBX = 10,
  parameter int MXHITB     = 3,
  parameter int MXPIDB     = 4,
  parameter int DEPTH      = 4,
  parameter int MXAGEB     = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [MXAGEB-1:0]     dead_bx,
  input  logic [4:0]            window_qs,
  input  logic                  cand_vld,
  input  logic [MXSUBKEYBX-1:0] cand_subkey,
  input  logic [MXHITB-1:0]     cand_nhits,
  input  logic [MXPIDB-1:0]     cand_pid,
  output logic                  out_vld,
  output logic [MXSUBKEYBX-1:0] out_subkey,
  output logic [MXHITB-1:0]     out_nhits,
  output logic [MXPIDB-1:0]     out_pid,
  output logic                  kill,
  output logic                  range_err
);
  import pattern_params::*;

  // DEPTH is a power of two >= 2, so the pointer wraps naturally.
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [MXSUBKEYBX-1:0] MAX_K = MXSUBKEYBX'(SUBKEY_MAX);

  logic                  r_vld_s1;
  logic                  r_rerr_s1;
  logic [MXSUBKEYBX-1:0] r_sk_s1;
  logic [MXHITB-1:0]     r_nh_s1;
  logic [MXPIDB-1:0]     r_pid_s1;
  logic [PTRW-1:0]       r_wr_ptr;

  logic [DEPTH-1:0]      w_match;
  logic                  w_ok_s1;
  logic                  w_kill;
  logic                  w_ins;

  // S1: register the candidate and flag out-of-range subkeys.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_vld_s1  <= 1'b0;
      r_rerr_s1 <= 1'b0;
      r_sk_s1   <= '0;
      r_nh_s1   <= '0;
      r_pid_s1  <= '0;
    end else begin
      r_vld_s1  <= cand_vld;
      r_rerr_s1 <= cand_vld & (cand_subkey > MAX_K);
      r_sk_s1   <= cand_subkey;
      r_nh_s1   <= cand_nhits;
      r_pid_s1  <= cand_pid;
    end
  end

  // S2: compare against history. Insertion happens on the same edge that
  // registers out_vld, so the next candidate sees the new entry at age 0.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    subkey_hist_entry #(
      .MXSUBKEYBX(MXSUBKEYBX),
      .MXHITB    (MXHITB),
      .MXAGEB    (MXAGEB)
    ) u_ent (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_wr         (w_ins && (r_wr_ptr == PTRW'(g))),
      .i_wr_subkey  (r_sk_s1),
      .i_wr_nhits   (r_nh_s1),
      .i_cand_subkey(r_sk_s1),
      .i_cand_nhits (r_nh_s1),
      .i_dead_bx    (dead_bx),
      .i_window_qs  (window_qs),
      .o_match      (w_match[g])
    );
  end

  assign w_ok_s1 = r_vld_s1 & ~r_rerr_s1;
  assign w_kill  = w_ok_s1 & (|w_match);
  assign w_ins   = w_ok_s1 & ~(|w_match);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_vld    <= 1'b0;
      kill       <= 1'b0;
      range_err  <= 1'b0;
      out_subkey <= '0;
      out_nhits  <= '0;
      out_pid    <= '0;
      r_wr_ptr   <= '0;
    end else begin
      out_vld   <= w_ins;
      kill      <= w_kill;
      range_err <= r_vld_s1 & r_rerr_s1;
      if (w_ins) begin
        out_subkey <= r_sk_s1;
        out_nhits  <= r_nh_s1;
        out_pid    <= r_pid_s1;
        r_wr_ptr   <= r_wr_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clct_subkey_deadtime.sv
module tb_clct_subkey_deadtime;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] dead_bx;
  logic [4:0] window_qs;
  logic       cand_vld;
  logic [9:0] cand_subkey;
  logic [2:0] cand_nhits;
  logic [3:0] cand_pid;
  logic       out_vld;
  logic [9:0] out_subkey;
  logic [2:0] out_nhits;
  logic [3:0] out_pid;
  logic       kill;
  logic       range_err;

  always #5 clock = ~clock;

  clct_subkey_deadtime dut (
    .clock(clock), .reset_n(reset_n), .dead_bx(dead_bx), .window_qs(window_qs),
    .cand_vld(cand_vld), .cand_subkey(cand_subkey), .cand_nhits(cand_nhits),
    .cand_pid(cand_pid), .out_vld(out_vld), .out_subkey(out_subkey),
    .out_nhits(out_nhits), .out_pid(out_pid), .kill(kill), .range_err(range_err)
  );

  localparam int EMIT = 0, KILL = 1, RERR = 2, NONE = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [9:0] sk;
    logic [2:0] nh;
    logic [3:0] pid;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bx of stimulus; expected outcome appears two clocks later.
  task automatic step(input logic v, input int sk, input int nh, input int pid, input int kind);
    exp_t e;
    @(negedge clock);
    cand_vld    = v;
    cand_subkey = 10'(sk);
    cand_nhits  = 3'(nh);
    cand_pid    = 4'(pid);
    if (v && kind != NONE) begin
      e.cyc = cyc + 2; e.kind = kind;
      e.sk = 10'(sk); e.nh = 3'(nh); e.pid = 4'(pid);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 0, NONE);
  endtask

  // Monitor: pop and compare whenever the DUT reports an outcome.
  always @(negedge clock) begin
    int   ak;
    exp_t e;
    if (out_vld || kill || range_err) begin
      if (out_vld && !kill && !range_err)      ak = EMIT;
      else if (kill && !out_vld && !range_err) ak = KILL;
      else if (range_err && !out_vld && !kill) ak = RERR;
      else                                     ak = 9;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: cyc %0d kind %0d, none expected", cyc, ak);
      end else begin
        e = q.pop_front();
        if (ak != e.kind || cyc != e.cyc ||
            (e.kind == EMIT && (out_subkey != e.sk || out_nhits != e.nh || out_pid != e.pid))) begin
          n_fail++;
          $display("FAIL outcome sk%0d: got kind %0d cyc %0d sk %0d nh %0d pid %0d, expected kind %0d cyc %0d sk %0d nh %0d pid %0d",
                   e.sk, ak, cyc, out_subkey, out_nhits, out_pid, e.kind, e.cyc, e.sk, e.nh, e.pid);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_out sk%0d: no outcome at cyc %0d, expected kind %0d", e.sk, cyc, e.kind);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; dead_bx = 4'd4; window_qs = 5'd8;
    cand_vld = 1'b0; cand_subkey = '0; cand_nhits = '0; cand_pid = '0;
    repeat (3) @(negedge clock);
    chk("reset_outs", {12'b0, out_vld, kill, range_err, out_subkey, out_nhits, out_pid}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Near candidate with fewer hits is killed.
    step(1, 100, 5, 1, EMIT);
    step(1, 106, 4, 2, KILL);
    idle(6);
    // Stronger second candidate is not suppressed.
    step(1, 100, 4, 3, EMIT);
    step(1, 103, 6, 4, EMIT);
    idle(6);
    chk("hold_subkey", 32'(out_subkey), 32'd103);
    chk("hold_nhits",  32'(out_nhits),  32'd6);
    chk("hold_pid",    32'(out_pid),    32'd4);
    // Age 4 == dead_bx: passes; age 3: killed.
    step(1, 100, 5, 5, EMIT);
    idle(4);
    step(1, 100, 3, 6, EMIT);
    idle(6);
    step(1, 200, 5, 7, EMIT);
    idle(3);
    step(1, 200, 3, 8, KILL);
    idle(6);
    // Window edge (diff 8 kills, equal hits), killed entry not inserted (309 vs 308).
    step(1, 300, 4, 9, EMIT);
    step(1, 308, 4, 10, KILL);
    step(1, 309, 4, 11, EMIT);
    idle(6);
    // Region boundary.
    step(1, 510, 4, 12, EMIT);
`ifdef SUBKEY_REGION_SPLIT_EN
    step(1, 514, 4, 13, EMIT);
`else
    step(1, 514, 4, 13, KILL);
`endif
    idle(6);
    // Range errors are neither emitted nor inserted; 895 is ordinary.
    step(1, 900, 7, 14, RERR);
    step(1, 902, 1, 15, RERR);
    step(1, 895, 1, 1, EMIT);
    step(1, 890, 1, 2, KILL);
    idle(3);
    chk("rerr_hold_subkey", 32'(out_subkey), 32'd895);

    // Fill past DEPTH: entry holding 0 is overwritten.
    @(negedge clock) reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    dead_bx = 4'd15;
    step(1, 0,   7, 1, EMIT);
    step(1, 200, 7, 2, EMIT);
    step(1, 400, 7, 3, EMIT);
    step(1, 600, 7, 4, EMIT);
    step(1, 800, 7, 5, EMIT);
    step(1, 2,   1, 6, EMIT);
    step(1, 803, 1, 7, KILL);
    idle(3);
    dead_bx = 4'd0;
    step(1, 801, 1, 8, EMIT);
    idle(3);
    dead_bx = 4'd15;

    // Mid-stream reset drops the in-flight candidate and clears history.
    step(1, 500, 2, 9, NONE);
    @(negedge clock);
    reset_n = 1'b0; cand_vld = 1'b0;
    @(negedge clock);
    chk("midreset_outs", {12'b0, out_vld, kill, range_err, out_subkey, out_nhits, out_pid}, 32'd0);
    reset_n = 1'b1;
    step(1, 803, 1, 10, EMIT);
    idle(4);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d outcomes never appeared, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
